// File: rtl/aes_masking_pkg.sv
// Shared definitions for the masked AES S-box engine: FSM states, table depth
// and the unmasked S-box used only during table recomputation.
package aes_masking_pkg;

    localparam int TABLE_DEPTH = 256;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        RECOMP = 2'd1,
        READY  = 2'd2
    } sbox_state_e;

    // Byte i lives at bits [(255-i)*8 +: 8], i.e. entry 0 is the MSB byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return SBOX_FLAT[{~b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/masked_table_ram.sv
// 256x8 masked lookup table: one synchronous write port, LANES asynchronous
// read ports (one per masked byte lane).
module masked_table_ram
    import aes_masking_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic               clk,
    input  logic               we,
    input  logic [7:0]         waddr,
    input  logic [7:0]         wdata,
    input  logic [8*LANES-1:0] raddr,
    output logic [8*LANES-1:0] rdata
);

    logic [7:0] mem [TABLE_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < LANES; k++) begin
            rdata[8*k +: 8] = mem[raddr[8*k +: 8]];
        end
    end

endmodule

// File: rtl/masked_sbox_engine.sv
// Multi-lane first-order masked AES S-box using table recomputation.
// Define MASKED_SBOX_SHUFFLE_EN to randomise the recomputation order via shuffle_seed.
module masked_sbox_engine
    import aes_masking_pkg::*;
#(
    parameter int LANES = 2,
    parameter int IDX_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mask_load,
    input  logic [7:0]         m_in,
    input  logic [7:0]         m_out,
`ifdef MASKED_SBOX_SHUFFLE_EN
    input  logic [7:0]         shuffle_seed,
`endif
    output logic               busy,
    output logic               table_ok,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data
);

    generate
        if (IDX_W != 8) begin : g_idx_w_check
            $error("masked_sbox_engine: IDX_W must be 8");
        end
        if (LANES < 1 || LANES > 16) begin : g_lanes_check
            $error("masked_sbox_engine: LANES must be 1..16");
        end
    endgenerate

    sbox_state_e        state_q, state_d;
    logic [7:0]         cnt_q;
    logic [7:0]         m_in_q, m_out_q;
    logic [7:0]         sbox_idx;
    logic               load_acc;
    logic               tbl_we;
    logic [7:0]         tbl_waddr, tbl_wdata;
    logic [8*LANES-1:0] tbl_rdata;
    logic               in_fire;
    logic               vld_p1;
    logic [8*LANES-1:0] out_data_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (mask_load) state_d = RECOMP;
            RECOMP:  if (cnt_q == 8'hFF) state_d = READY;
            READY:   if (mask_load) state_d = RECOMP;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        busy     = (state_q == RECOMP);
        table_ok = (state_q == READY);
        tbl_we   = (state_q == RECOMP);
        load_acc = mask_load && (state_q != RECOMP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'h00;
        end else if (load_acc) begin
            cnt_q <= 8'h00;
        end else if (state_q == RECOMP) begin
            cnt_q <= cnt_q + 8'h01;
        end
    end

    // Masks are captured only on entry; loads during recomputation are dropped.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            m_in_q  <= m_in;
            m_out_q <= m_out;
        end
    end

`ifdef MASKED_SBOX_SHUFFLE_EN
    logic [7:0] seed_q;

    always_ff @(posedge clk) begin
        if (load_acc) begin
            seed_q <= shuffle_seed;
        end
    end

    assign sbox_idx = cnt_q ^ seed_q;
`else
    assign sbox_idx = cnt_q;
`endif

    // Only the masked address and masked S-box value reach the table.
    assign tbl_waddr = sbox_idx ^ m_in_q;
    assign tbl_wdata = aes_sbox(sbox_idx) ^ m_out_q;

    masked_table_ram #(
        .LANES (LANES)
    ) u_table (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (tbl_waddr),
        .wdata (tbl_wdata),
        .raddr (in_data),
        .rdata (tbl_rdata)
    );

    assign in_ready = (state_q == READY) && (!vld_p1 || out_ready);
    assign in_fire  = in_valid && in_ready;

    // Stage p1: registered lookup result, independent of recomputation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            out_data_p1 <= '0;
        end else if (in_fire) begin
            vld_p1      <= 1'b1;
            out_data_p1 <= tbl_rdata;
        end else if (out_ready) begin
            vld_p1      <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = out_data_p1;

endmodule

// File: doc/masked_sbox_engine.md
Name: masked_sbox_engine

Overview:
- Multi-lane, first-order Boolean-masked AES S-box engine using table recomputation. It is the pipelined, parametrised successor of the single-byte masked S-box lookup.
- On a mask load, the block rebuilds a 256-entry masked table T such that T[a ^ m_in] = S(a) ^ m_out.
- It then serves LANES masked byte lookups per beat through a valid/ready stream with a registered output.
- It sits between the masked AES round datapath (SubBytes stage) and the mask generator.

Parameters:
- LANES, 2, number of masked bytes looked up per beat (1..16).
- IDX_W, 8, table index width; fixed at 8 for AES. Any other value triggers an elaboration error.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- mask_load  input  1  pulse: sample m_in/m_out and start table recomputation
- m_in  input  8  input mask applied to in_data bytes
- m_out  input  8  output mask to apply to out_data bytes
- busy  output  1  table recomputation in progress
- table_ok  output  1  a complete masked table is present
- in_valid  input  1  in_data valid
- in_ready  output  1  engine accepts in_data this cycle
- in_data  input  8*LANES  masked bytes x^m_in; lane k at [8k+7:8k]
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- out_data  output  8*LANES  S(x)^m_out per lane

Behaviour:
- Reset state: busy=0, table_ok=0, out_valid=0, out_data=0, in_ready=0, FSM=EMPTY, counter=0. Table contents are don't-care.
- FSM states and transitions:
  - EMPTY: no valid table.
  - RECOMP: table is being rebuilt.
  - READY: table valid.
  - EMPTY/READY -> RECOMP on mask_load=1.
  - RECOMP -> READY after the write with counter=255.
  - In RECOMP, mask_load is ignored; masks latched at entry are kept.
- Recomputation:
  - 8-bit counter i runs 0..255.
  - One write per cycle: table[i ^ m_in_q] <= S(i) ^ m_out_q.
  - Exactly 256 cycles.
  - If mask_load is seen at edge t, busy is high for edges t+1..t+256. table_ok and in_ready can rise after edge t+256.
  - table_ok=1 in READY only; it drops the cycle after mask_load is accepted.
- Input handshake:
  - in_ready = (FSM==READY) && (!out_valid || out_ready).
  - A beat transfers when in_valid && in_ready.
- Simultaneous transfer and mask_load in READY: the beat uses the old table (result masked with the old m_out), and recomputation starts the next cycle.
- Lookup:
  - Lane k reads table[in_data lane k]; results are registered into out_data.
  - Latency 1: the transfer at edge t gives out_valid=1 after edge t.
- Output:
  - out_valid/out_data hold stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new beat transfers the same cycle (full throughput, 1 beat/cycle).
- The output register is independent of recomputation. A pending output survives mask_load and completes with the old mask.
- Unmasked values never appear in any register: only i, S(i)^m_out and masked indices/data are stored.
- Async reset mid-RECOMP: return to EMPTY, table_ok=0. Recomputation does not resume.

Optional Feature:
- Macro: MASKED_SBOX_SHUFFLE_EN.
- Defined:
  - Adds input port shuffle_seed[7:0], sampled with mask_load.
  - The write order becomes j = i ^ seed_q, writing table[j ^ m_in_q] <= S(j) ^ m_out_q.
  - Same final table and same 256-cycle duration; the S-box evaluation order is randomised per recomputation.
- Undefined: port absent; sequential order j = i.

Decomposition:
- Package aes_masking_pkg:
  - function aes_sbox(byte) returning the unmasked S-box value;
  - localparam TABLE_DEPTH=256;
  - FSM state enum {EMPTY, RECOMP, READY}.
- One sub-module masked_table_ram: 256x8 register array, one write port, LANES combinational read ports.
- The FSM, handshake and output register stay in the top.

Test Plan:
- Reset then idle: after rst_n release, in_ready=0, table_ok=0, out_valid=0; in_valid=1 is never accepted.
- m_in=0x5A, m_out=0xC3, mask_load pulse: busy high exactly 256 cycles, then table_ok=1. Send lanes {0x57, 0xA8} -> out_data {0x14, 0x4A} (S(0x0D)=0xD7, S(0xF2)=0x89), one cycle later.
- Masks 0x00/0x00, stream 256 beats covering all bytes, out_ready=1 -> out_data equals aes_sbox each cycle, throughput 1 beat/cycle.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data stable and in_ready=0; releasing out_ready resumes with no loss or duplication.
- mask_load the same cycle as a transfer (old masks 0x5A/0xC3, new masks 0x11/0x22) -> that beat returns old-mask results. mask_load during busy is ignored. After 256 cycles, input 0x55^0x11=0x44 -> output 0xFC^0x22=0xDE.
- rst_n asserted at recompute cycle 100 -> busy=0, table_ok=0 immediately. With MASKED_SBOX_SHUFFLE_EN, seed 0xA5 gives a table identical to the unshuffled run.
